// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle core control path
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_S,
      CLS_B,
      CLS_U,
      CLS_J,
      CLS_ILLEGAL
   } inst_class_e;

   localparam logic [6:0] OPCODE_R    = 7'b0110011;
   localparam logic [6:0] OPCODE_I    = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
   localparam logic [6:0] OPCODE_S    = 7'b0100011;
   localparam logic [6:0] OPCODE_B    = 7'b1100011;
   localparam logic [6:0] OPCODE_U    = 7'b0110111;
   localparam logic [6:0] OPCODE_J    = 7'b1101111;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_PASS_B = 4'd4;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_UIMM = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] WDATA_ALU = 2'b00;
   localparam logic [1:0] WDATA_IMM = 2'b01;
   localparam logic [1:0] WDATA_MEM = 2'b10;
   localparam logic [1:0] WDATA_PC4 = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   function automatic inst_class_e decode_class(input logic [6:0] opcode);
      case (opcode)
         OPCODE_R:    return CLS_R;
         OPCODE_I:    return CLS_I;
         OPCODE_LOAD: return CLS_LOAD;
         OPCODE_S:    return CLS_S;
         OPCODE_B:    return CLS_B;
         OPCODE_U:    return CLS_U;
         OPCODE_J:    return CLS_J;
         default:     return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the control FSM and the datapath
interface multicycle_ctrl_if;
   logic [31:0] instruction;
   logic        mem_ready;
   logic        branch_taken;
   logic        pc_we;
   logic        pc_src;
   logic        ir_we;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_src;
   logic        rf_we;
   logic [1:0]  rf_wdata_src;
   logic [3:0]  alu_op;
   logic [1:0]  alu_src_b;
   logic        retire;
   logic        halted;
   logic [1:0]  cause;
   logic [2:0]  state;

   modport master (
      input  instruction, mem_ready, branch_taken,
      output pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src, rf_we,
             rf_wdata_src, alu_op, alu_src_b, retire, halted, cause, state
   );

   modport slave (
      output instruction, mem_ready, branch_taken,
      input  pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src, rf_we,
             rf_wdata_src, alu_op, alu_src_b, retire, halted, cause, state
   );
endinterface

// File: rtl/alu_ctrl_map.sv
// rtl/alu_ctrl_map.sv - opcode/funct3/funct7 to ALU operation and operand-B select
module alu_ctrl_map
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_op,
   output logic [1:0] alu_src_b
);
   always_comb begin
      alu_op    = ALU_ADD;
      alu_src_b = SRCB_RS2;
      case (decode_class(opcode))
         CLS_R: begin
            case (funct3)
               3'b000:  alu_op = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               default: alu_op = ALU_ADD;
            endcase
         end
         CLS_I: begin
            alu_src_b = SRCB_IMM;
            case (funct3)
               3'b110:  alu_op = ALU_OR;
               3'b111:  alu_op = ALU_AND;
               default: alu_op = ALU_ADD;
            endcase
         end
         CLS_LOAD, CLS_S, CLS_J: alu_src_b = SRCB_IMM;
         CLS_U: begin
            alu_op    = ALU_PASS_B;
            alu_src_b = SRCB_UIMM;
         end
         // Branch compare is rs1 - rs2; the target adder lives in the datapath.
         CLS_B:   alu_op = ALU_SUB;
         default: alu_op = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and halt
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             halted_q;
   logic [1:0]       cause_q, cause_d;
   inst_class_e      cls;
   logic [3:0]       map_alu_op;
   logic [1:0]       map_alu_src_b;
   logic             mem_phase;
   logic             timeout;
   logic             unused_ir_bits;

   logic       pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src, rf_we, retire;
   logic [1:0] rf_wdata_src, alu_src_b;
   logic [3:0] alu_op;

   assign cls            = decode_class(bus.instruction[6:0]);
   assign unused_ir_bits = ^{bus.instruction[24:15], bus.instruction[11:7]};

   alu_ctrl_map u_alu_ctrl_map (
      .opcode    (bus.instruction[6:0]),
      .funct3    (bus.instruction[14:12]),
      .funct7    (bus.instruction[31:25]),
      .alu_op    (map_alu_op),
      .alu_src_b (map_alu_src_b)
   );

   // A ready in the limit cycle still completes; only a missing ready there times out.
   assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign timeout   = mem_phase && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      ir_we        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      rf_we        = 1'b0;
      rf_wdata_src = WDATA_ALU;
      alu_op       = ALU_ADD;
      alu_src_b    = SRCB_RS2;
      retire       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_HALT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (cls == CLS_ILLEGAL) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_op    = map_alu_op;
            alu_src_b = map_alu_src_b;
            case (cls)
               CLS_R, CLS_I, CLS_U: state_d = ST_WB;
               CLS_LOAD, CLS_S:     state_d = ST_MEM;
               CLS_B: begin
                  pc_we   = 1'b1;
                  pc_src  = bus.branch_taken;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
               CLS_J: begin
                  rf_we        = 1'b1;
                  rf_wdata_src = WDATA_PC4;
                  pc_we        = 1'b1;
                  pc_src       = 1'b1;
                  retire       = 1'b1;
                  state_d      = ST_FETCH;
               end
               default: begin
                  state_d = ST_HALT;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_src = 1'b1;
            mem_we       = (cls == CLS_S);
            if (bus.mem_ready) begin
               if (cls == CLS_S) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (timeout) begin
               state_d = ST_HALT;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_WB: begin
            rf_we = 1'b1;
            case (cls)
               CLS_U:    rf_wdata_src = WDATA_IMM;
               CLS_LOAD: rf_wdata_src = WDATA_MEM;
               default:  rf_wdata_src = WDATA_ALU;
            endcase
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            state_d = ST_HALT;
            cause_d = CAUSE_ILLEGAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_FETCH;
         wait_cnt <= '0;
         halted_q <= 1'b0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         halted_q <= (state_d == ST_HALT);
         if (state_d != state_q) begin
            wait_cnt <= '0;
         end else if (mem_phase && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   // Strobes are masked while reset is low so an in-flight access drops at once.
   assign bus.pc_we        = rst & pc_we;
   assign bus.pc_src       = rst & pc_src;
   assign bus.ir_we        = rst & ir_we;
   assign bus.mem_req      = rst & mem_req;
   assign bus.mem_we       = rst & mem_we;
   assign bus.mem_addr_src = rst & mem_addr_src;
   assign bus.rf_we        = rst & rf_we;
   assign bus.retire       = rst & retire;
   assign bus.rf_wdata_src = rst ? rf_wdata_src : 2'b00;
   assign bus.alu_op       = rst ? alu_op : 4'd0;
   assign bus.alu_src_b    = rst ? alu_src_b : 2'b00;
   assign bus.halted       = halted_q;
   assign bus.cause        = cause_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table, corner-sequence and random checks for multicycle_ctrl
module tb_multicycle_ctrl;
   localparam int TMO = 4;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_PASS = 4'd4;
   localparam logic [1:0] B_RS2 = 2'd0, B_UIMM = 2'd1, B_IMM = 2'd2;
   // strobe order: pc_we pc_src ir_we mem_req mem_we mem_addr_src rf_we
   localparam logic [6:0] S_NONE = 7'b0000000, S_FREQ = 7'b0001000, S_IRLD = 7'b0011000;
   localparam logic [6:0] S_MRD = 7'b0001010, S_MWR = 7'b0001110, S_STDN = 7'b1001110;
   localparam logic [6:0] S_WB = 7'b1000001, S_BRT = 7'b1100000, S_BRN = 7'b1000000, S_JAL = 7'b1100001;

   localparam logic [31:0] I_ADDI = 32'h00500093, I_LW = 32'h0000A103, I_BEQ = 32'h00208463;
   localparam logic [31:0] I_JAL = 32'h008000EF, I_SW = 32'h0020A223, I_LUI = 32'h123450B7;
   localparam logic [31:0] I_SUB = 32'h40208033, I_ILL = 32'hFFFFFFFF;

   typedef struct packed {
      logic [2:0] state;
      logic       pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src, rf_we;
      logic [1:0] rf_wdata_src;
      logic [3:0] alu_op;
      logic [1:0] alu_src_b;
      logic       retire, halted;
      logic [1:0] cause;
   } outs_t;

   typedef struct {
      logic        rs;
      logic [31:0] ins;
      logic        rdy;
      logic        br;
      outs_t       exp;
      string       tag;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst;
   int    n_vec = 0;
   int    n_bad = 0;
   string tag = "";
   vec_t  tbl[$];
   outs_t act;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic outs_t mk(input logic [2:0] st, input logic [6:0] sb, input logic [1:0] wd,
                                input logic [3:0] op, input logic [1:0] srcb, input logic ret,
                                input logic hlt, input logic [1:0] cs);
      outs_t o;
      o.state = st;
      {o.pc_we, o.pc_src, o.ir_we, o.mem_req, o.mem_we, o.mem_addr_src, o.rf_we} = sb;
      o.rf_wdata_src = wd;
      o.alu_op       = op;
      o.alu_src_b    = srcb;
      o.retire       = ret;
      o.halted       = hlt;
      o.cause        = cs;
      return o;
   endfunction

   function automatic outs_t ms(input logic [2:0] st, input logic [6:0] sb);
      return mk(st, sb, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic outs_t mx(input logic [3:0] op, input logic [1:0] srcb);
      return mk(3'd2, S_NONE, 2'd0, op, srcb, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic outs_t mh(input logic [1:0] cs);
      return mk(3'd5, S_NONE, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1, cs);
   endfunction

   function automatic vec_t v(input logic rs, input logic [31:0] ins, input logic rdy,
                              input logic br, input outs_t e);
      vec_t r;
      r.rs = rs; r.ins = ins; r.rdy = rdy; r.br = br; r.exp = e; r.tag = tag;
      return r;
   endfunction

   task automatic row(input logic rs, input logic [31:0] ins, input logic rdy, input logic br,
                      input outs_t e);
      tbl.push_back(v(rs, ins, rdy, br, e));
   endtask

   task automatic apply(input vec_t x);
      rst              = x.rs;
      bus.instruction  = x.ins;
      bus.mem_ready    = x.rdy;
      bus.branch_taken = x.br;
      #2;
      act.state = bus.state;
      {act.pc_we, act.pc_src, act.ir_we, act.mem_req, act.mem_we, act.mem_addr_src, act.rf_we} =
         {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_req, bus.mem_we, bus.mem_addr_src, bus.rf_we};
      act.rf_wdata_src = bus.rf_wdata_src;
      act.alu_op       = bus.alu_op;
      act.alu_src_b    = bus.alu_src_b;
      act.retire       = bus.retire;
      act.halted       = bus.halted;
      act.cause        = bus.cause;
      n_vec++;
      if (act !== x.exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %b required %b (state|strobes|wd|alu|srcb|ret|halt|cause)",
                  x.tag, n_vec, act, x.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_all();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      tbl.delete();
   endtask

   // ---------------- reference model: one instruction expanded to its cycle list
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int classify(input logic [6:0] opc);
      case (opc)
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         7'b0110111: return 5;
         7'b1101111: return 6;
         default:    return 7;
      endcase
   endfunction

   function automatic logic [5:0] ref_alu(input logic [31:0] ins);
      logic [2:0] f3;
      f3 = ins[14:12];
      case (classify(ins[6:0]))
         0: begin
            if (f3 == 3'b000) return {(ins[31:25] == 7'h20) ? A_SUB : A_ADD, B_RS2};
            if (f3 == 3'b110) return {A_OR, B_RS2};
            if (f3 == 3'b111) return {A_AND, B_RS2};
            return {A_ADD, B_RS2};
         end
         1: begin
            if (f3 == 3'b110) return {A_OR, B_IMM};
            if (f3 == 3'b111) return {A_AND, B_IMM};
            return {A_ADD, B_IMM};
         end
         4:       return {A_SUB, B_RS2};
         5:       return {A_PASS, B_UIMM};
         default: return {A_ADD, B_IMM};
      endcase
   endfunction

   task automatic halt_then_reset(input logic [31:0] ins, input logic [1:0] cs);
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) row(1'b1, ins, rb(), rb(), mh(cs));
      row(1'b0, ins, rb(), rb(), mh(cs));
   endtask

   task automatic gen_instr(input logic [31:0] ins, input int wf, input int wm);
      int         cls;
      logic [5:0] a;
      logic       br;
      logic [6:0] msb;
      cls = classify(ins[6:0]);
      a   = ref_alu(ins);
      for (int k = 0; k < wf && k <= TMO; k++) row(1'b1, ins, 1'b0, rb(), ms(3'd0, S_FREQ));
      if (wf > TMO) begin halt_then_reset(ins, 2'd2); return; end
      row(1'b1, ins, 1'b1, rb(), ms(3'd0, S_IRLD));
      row(1'b1, ins, rb(), rb(), ms(3'd1, S_NONE));
      if (cls == 7) begin halt_then_reset(ins, 2'd1); return; end
      if (cls == 4) begin
         br = rb();
         row(1'b1, ins, rb(), br, mk(3'd2, {1'b1, br, 5'b0}, 2'd0, a[5:2], a[1:0], 1'b1, 1'b0, 2'd0));
         return;
      end
      if (cls == 6) begin
         row(1'b1, ins, rb(), rb(), mk(3'd2, S_JAL, 2'd3, a[5:2], a[1:0], 1'b1, 1'b0, 2'd0));
         return;
      end
      row(1'b1, ins, rb(), rb(), mx(a[5:2], a[1:0]));
      if (cls == 2 || cls == 3) begin
         msb = (cls == 3) ? S_MWR : S_MRD;
         for (int k = 0; k < wm && k <= TMO; k++) row(1'b1, ins, 1'b0, rb(), ms(3'd3, msb));
         if (wm > TMO) begin halt_then_reset(ins, 2'd2); return; end
         if (cls == 3) begin
            row(1'b1, ins, 1'b1, rb(), mk(3'd3, S_STDN, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
            return;
         end
         row(1'b1, ins, 1'b1, rb(), ms(3'd3, S_MRD));
      end
      row(1'b1, ins, rb(), rb(),
          mk(3'd4, S_WB, (cls == 5) ? 2'd1 : (cls == 2) ? 2'd2 : 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  opc;
      int          k;
      ins = $urandom;
      k   = $urandom_range(0, 7);
      case (k)
         0: begin
            opc = 7'b0110011;
            if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h20;
            else if ($urandom_range(0, 1) == 0) ins[31:25] = 7'h00;
         end
         1: opc = 7'b0010011;
         2: opc = 7'b0000011;
         3: opc = 7'b0100011;
         4: opc = 7'b1100011;
         5: opc = 7'b0110111;
         6: opc = 7'b1101111;
         default: begin
            opc = 7'($urandom);
            while (classify(opc) != 7) opc = 7'($urandom);
         end
      endcase
      ins[6:0] = opc;
      return ins;
   endfunction

   function automatic int rand_wait();
      int r;
      r = $urandom_range(0, 11);
      return (r < 6) ? 0 : r - 6;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      rst              = 1'b0;
      bus.instruction  = 32'h0;
      bus.mem_ready    = 1'b0;
      bus.branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // ---------------- directed table
      tag = "reset";   row(1'b0, 32'h0, 1'b1, 1'b0, ms(3'd0, S_NONE));
      tag = "addi";    row(1'b1, I_ADDI, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_ADDI, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_ADDI, 1'b1, 1'b0, mx(A_ADD, B_IMM));
                       row(1'b1, I_ADDI, 1'b1, 1'b0, mk(3'd4, S_WB, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
      tag = "lw_wait"; row(1'b1, I_LW, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_LW, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_LW, 1'b1, 1'b0, mx(A_ADD, B_IMM));
                       for (int k = 0; k < 3; k++) row(1'b1, I_LW, 1'b0, 1'b0, ms(3'd3, S_MRD));
                       row(1'b1, I_LW, 1'b1, 1'b0, ms(3'd3, S_MRD));
                       row(1'b1, I_LW, 1'b1, 1'b0, mk(3'd4, S_WB, 2'd2, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
      tag = "beq_t";   row(1'b1, I_BEQ, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_BEQ, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_BEQ, 1'b1, 1'b1, mk(3'd2, S_BRT, 2'd0, A_SUB, B_RS2, 1'b1, 1'b0, 2'd0));
      tag = "beq_n";   row(1'b1, I_BEQ, 1'b1, 1'b1, ms(3'd0, S_IRLD));
                       row(1'b1, I_BEQ, 1'b1, 1'b1, ms(3'd1, S_NONE));
                       row(1'b1, I_BEQ, 1'b1, 1'b0, mk(3'd2, S_BRN, 2'd0, A_SUB, B_RS2, 1'b1, 1'b0, 2'd0));
      tag = "jal";     row(1'b1, I_JAL, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_JAL, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_JAL, 1'b1, 1'b0, mk(3'd2, S_JAL, 2'd3, A_ADD, B_IMM, 1'b1, 1'b0, 2'd0));
      tag = "sw";      row(1'b1, I_SW, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_SW, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_SW, 1'b1, 1'b0, mx(A_ADD, B_IMM));
                       row(1'b1, I_SW, 1'b1, 1'b0, mk(3'd3, S_STDN, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
      tag = "lui";     row(1'b1, I_LUI, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_LUI, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_LUI, 1'b1, 1'b0, mx(A_PASS, B_UIMM));
                       row(1'b1, I_LUI, 1'b1, 1'b0, mk(3'd4, S_WB, 2'd1, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
      tag = "sub_x0";  row(1'b1, I_SUB, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_SUB, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_SUB, 1'b1, 1'b0, mx(A_SUB, B_RS2));
                       row(1'b1, I_SUB, 1'b1, 1'b0, mk(3'd4, S_WB, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0));
      tag = "rst_mid"; row(1'b1, I_LW, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_LW, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_LW, 1'b1, 1'b0, mx(A_ADD, B_IMM));
                       row(1'b1, I_LW, 1'b0, 1'b0, ms(3'd3, S_MRD));
                       row(1'b0, I_LW, 1'b1, 1'b0, ms(3'd3, S_NONE));
      tag = "illegal"; row(1'b1, I_ILL, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b1, I_ILL, 1'b1, 1'b0, ms(3'd1, S_NONE));
                       row(1'b1, I_ILL, 1'b1, 1'b1, mh(2'd1));
                       row(1'b1, I_ILL, 1'b1, 1'b1, mh(2'd1));
                       row(1'b0, I_ILL, 1'b1, 1'b1, mh(2'd1));
      tag = "post_rst"; row(1'b1, I_ADDI, 1'b1, 1'b0, ms(3'd0, S_IRLD));
                       row(1'b0, I_ADDI, 1'b1, 1'b0, ms(3'd1, S_NONE));
      apply_all();

      // ---------------- hand-written timeout corners
      tag = "fetch_timeout";
      for (int k = 0; k <= TMO; k++) apply(v(1'b1, I_ADDI, 1'b0, 1'b0, ms(3'd0, S_FREQ)));
      for (int k = 0; k < 3; k++) apply(v(1'b1, I_ADDI, 1'b1, 1'b0, mh(2'd2)));
      apply(v(1'b0, I_ADDI, 1'b1, 1'b0, mh(2'd2)));

      tag = "fetch_edge";
      for (int k = 0; k < TMO; k++) apply(v(1'b1, I_LW, 1'b0, 1'b0, ms(3'd0, S_FREQ)));
      apply(v(1'b1, I_LW, 1'b1, 1'b0, ms(3'd0, S_IRLD)));
      apply(v(1'b1, I_LW, 1'b0, 1'b0, ms(3'd1, S_NONE)));
      apply(v(1'b1, I_LW, 1'b0, 1'b0, mx(A_ADD, B_IMM)));
      tag = "mem_edge";
      for (int k = 0; k < TMO; k++) apply(v(1'b1, I_LW, 1'b0, 1'b0, ms(3'd3, S_MRD)));
      apply(v(1'b1, I_LW, 1'b1, 1'b0, ms(3'd3, S_MRD)));
      apply(v(1'b1, I_LW, 1'b0, 1'b0, mk(3'd4, S_WB, 2'd2, 4'd0, 2'd0, 1'b1, 1'b0, 2'd0)));

      tag = "mem_timeout";
      apply(v(1'b1, I_SW, 1'b1, 1'b0, ms(3'd0, S_IRLD)));
      apply(v(1'b1, I_SW, 1'b0, 1'b0, ms(3'd1, S_NONE)));
      apply(v(1'b1, I_SW, 1'b0, 1'b0, mx(A_ADD, B_IMM)));
      for (int k = 0; k <= TMO; k++) apply(v(1'b1, I_SW, 1'b0, 1'b0, ms(3'd3, S_MWR)));
      apply(v(1'b1, I_SW, 1'b1, 1'b0, mh(2'd2)));
      apply(v(1'b0, I_SW, 1'b1, 1'b0, mh(2'd2)));

      // ---------------- random instruction stream against the reference model
      tag = "random";
      for (int n = 0; n < 300; n++) gen_instr(rand_instr(), rand_wait(), rand_wait());
      apply_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
